// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the packed-BCD to binary converter.
// The requester (master) drives start/bcd and observes the result;
// the converter (slave) returns number/busy/done/error.
interface bcd_to_bin_if #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [WIDTH-1:0]      number;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start,
        output bcd,
        input  number,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  bcd,
        output number,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One right shift of {digits, binary} per cycle; after each shift every
// BCD digit that reads >= 8 has 3 subtracted, which undoes the "x10"
// weighting as bits migrate from the decimal field into the binary field.
// Optional feature: define BCD2BIN_CHECK_EN to reject operands holding a
// digit > 9 (number=0, error=1, done one cycle after acceptance). Without
// it error is constant 0 and every operand takes 4*DIGITS shift cycles.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    bcd_to_bin_if.slave   bus
);
    localparam int BITS  = 4 * DIGITS;
    localparam int CNT_W = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   digit_q, digit_d;
    logic [BITS-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  number_q, number_d;
    logic              error_q, error_d;
    logic              badFlag_q, badFlag_d;

    logic [2*BITS-1:0] shifted;
    logic [BITS-1:0]   digitCorr;
    logic              badOperand;
    logic              finish;

`ifdef BCD2BIN_CHECK_EN
    // Flag an operand that contains any non-decimal digit
    always_comb begin
        badOperand = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) begin
                badOperand = 1'b1;
            end
        end
    end
`else
    assign badOperand = 1'b0;
`endif

    // A rejected operand finishes after its single CONV cycle; otherwise on the last shift
    assign finish = badFlag_q || (cnt_q == CNT_W'(BITS - 1));

    // One shift step: move {D,B} right by one, then correct every digit of D that is >= 8
    always_comb begin
        shifted   = {digit_q, bin_q} >> 1;
        digitCorr = shifted[2*BITS-1:BITS];
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BITS + 4*i + 3]) begin
                digitCorr[4*i +: 4] = shifted[BITS + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Datapath next values: capture on accept, shift in CONV, publish result on completion
    always_comb begin
        digit_d   = digit_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        number_d  = number_q;
        error_d   = error_q;
        badFlag_d = badFlag_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    digit_d   = bus.bcd;
                    bin_d     = '0;
                    cnt_d     = '0;
                    badFlag_d = badOperand;
                end
            end
            CONV: begin
                if (badFlag_q) begin
                    number_d  = '0;
                    error_d   = 1'b1;
                    badFlag_d = 1'b0;
                end else begin
                    digit_d = digitCorr;
                    bin_d   = shifted[BITS-1:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (finish) begin
                        number_d = WIDTH'(shifted[BITS-1:0]);
                        error_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared asynchronously so an aborted conversion leaves nothing behind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q   <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            number_q  <= '0;
            error_q   <= 1'b0;
            badFlag_q <= 1'b0;
        end else begin
            digit_q   <= digit_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            number_q  <= number_d;
            error_q   <= error_d;
            badFlag_q <= badFlag_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only matters in IDLE, DONE always lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (finish)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy while converting, done for the single DONE cycle
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            CONV:    bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.number = number_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin (DIGITS=3, WIDTH=10).
// Stimulus pushes the hand-computed result for each accepted start;
// an independent monitor pops and compares on every done pulse.
module tb_bcd_to_bin;
    localparam int DIGITS = 3;
    localparam int WIDTH  = 10;

    typedef struct {
        logic [WIDTH-1:0] num;
        logic             err;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t expQ[$];

    bcd_to_bin_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got number=%0h with nothing expected", bus.number);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("number", 32'(bus.number), 32'(e.num));
                checkOutput("error", 32'(bus.error), 32'(e.err));
            end
        end
    end

    // One conversion from an idle DUT; optionally alter bcd mid-conversion at cycle changeAt
    task automatic applyStimulus(input logic [11:0] bcdVal, input logic [9:0] expNum,
                                 input logic expErr, input int expLat,
                                 input int changeAt, input logic [11:0] newBcd);
        int cycles;
        int busyCycles;
        @(negedge clk);
        bus.bcd   = bcdVal;
        bus.start = 1'b1;
        expQ.push_back('{expNum, expErr});
        @(posedge clk);
        #1 bus.start = 1'b0;
        cycles     = 0;
        busyCycles = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busyCycles++;
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == changeAt) bus.bcd = newBcd;
        end
        checkOutput("latency", 32'(cycles), 32'(expLat));
        checkOutput("busyCycles", 32'(busyCycles), 32'(expLat));
        @(posedge clk);
        #1;
        checkOutput("donePulseWidth", 32'(bus.done), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int doneCount;
        int firstDone;
        int waited;
        bus.start = 1'b0;
        bus.bcd   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetNumber", 32'(bus.number), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetDone", 32'(bus.done), 32'd0);
        checkOutput("resetError", 32'(bus.error), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(12'h999, 10'h3E7, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h255, 10'h0FF, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h000, 10'h000, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h001, 10'h001, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h009, 10'h009, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h090, 10'h05A, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h100, 10'h064, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h512, 10'h200, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h042, 10'h02A, 1'b0, 12, 5, 12'h876);

`ifdef BCD2BIN_CHECK_EN
        applyStimulus(12'h9A9, 10'h000, 1'b1, 1, 0, 12'h000);
        applyStimulus(12'h010, 10'h00A, 1'b0, 12, 0, 12'h000);
        applyStimulus(12'h00F, 10'h000, 1'b1, 1, 0, 12'h000);
        applyStimulus(12'hA00, 10'h000, 1'b1, 1, 0, 12'h000);
`endif

        // Start held for 20 edges: only one done inside the window; because start
        // is level-sampled, the DUT re-accepts on the first IDLE cycle after done
        @(negedge clk);
        bus.bcd   = 12'h123;
        bus.start = 1'b1;
        expQ.push_back('{10'h07B, 1'b0});
        expQ.push_back('{10'h07B, 1'b0});
        doneCount = 0;
        firstDone = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                doneCount++;
                if (firstDone == 0) firstDone = c;
            end
        end
        bus.start = 1'b0;
        checkOutput("heldStartDoneCount", 32'(doneCount), 32'd1);
        checkOutput("heldStartFirstDone", 32'(firstDone), 32'd13);
        waited = 0;
        while (!bus.done && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("heldStartReaccept", 32'(waited), 32'd7);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        bus.bcd   = 12'h123;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("preResetBusy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncResetNumber", 32'(bus.number), 32'd0);
        checkOutput("asyncResetBusy", 32'(bus.busy), 32'd0);
        checkOutput("asyncResetDone", 32'(bus.done), 32'd0);
        checkOutput("asyncResetError", 32'(bus.error), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) doneCount++;
        end
        checkOutput("noActivityAfterReset", 32'(doneCount), 32'd0);

        applyStimulus(12'h999, 10'h3E7, 1'b0, 12, 0, 12'h000);

        repeat (3) @(posedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
